// File: rtl/prog_pkg.sv
// Shared definitions for the CPU controller and the burst programmer:
// control-word bit indices, the idle control word, the programmer state enum
// and a helper that asserts exactly one control line.
package prog_pkg;

  localparam int unsigned CTRL_W = 15;

  // Control word bit indices (suffix _N marks an active-low line)
  localparam logic [3:0] SIG_PC_INC          = 4'd14;
  localparam logic [3:0] SIG_PC_OUT          = 4'd13;
  localparam logic [3:0] SIG_PC_JUMP         = 4'd12;
  localparam logic [3:0] SIG_MAR_ADDR_LOAD_N = 4'd11;
  localparam logic [3:0] SIG_MAR_MEM_LOAD_N  = 4'd10;
  localparam logic [3:0] SIG_RAM_EN_N        = 4'd9;
  localparam logic [3:0] SIG_RAM_LOAD_N      = 4'd8;
  localparam logic [3:0] SIG_IR_LOAD_N       = 4'd7;
  localparam logic [3:0] SIG_IR_EN_N         = 4'd6;
  localparam logic [3:0] SIG_A_LOAD_N        = 4'd5;
  localparam logic [3:0] SIG_A_EN            = 4'd4;
  localparam logic [3:0] SIG_ALU_EN          = 4'd3;
  localparam logic [3:0] SIG_ALU_SUB         = 4'd2;
  localparam logic [3:0] SIG_B_LOAD_N        = 4'd1;
  localparam logic [3:0] SIG_OUT_LOAD_N      = 4'd0;

  // Every line at its inactive level
  localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'b000111111100011;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ADDR,
    DATA,
    WRITE,
    READ,
    CHECK
  } prog_state_t;

  // Idle control word with a single line driven to its active level
  function automatic logic [CTRL_W-1:0] ctrl_assert(input logic [3:0] sig);
    logic [CTRL_W-1:0] w;
    w      = CTRL_IDLE;
    w[sig] = ~w[sig];
    return w;
  endfunction

endpackage

// File: rtl/prog_addr_counter.sv
// Write-address and word-count tracker for the burst programmer.
// Loads the base address at session start, advances by one (wrapping modulo
// 2**ADDR_W) after each completed write, and flags full after DEPTH writes.
module prog_addr_counter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              full,
  output logic              last
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [ADDR_W:0] count;

  // The next increment completes the DEPTH-th write of the session
  assign last = ((count + ONE_C) == DEPTH_C);

  // Address, count and full flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (load) begin
      addr  <= base;
      count <= '0;
      full  <= 1'b0;
    end else if (inc) begin
      addr  <= addr + ADDR_W'(1);
      count <= count + ONE_C;
      full  <= last;
    end
  end

endmodule

// File: rtl/burst_programmer.sv
// Burst RAM programmer: accepts bytes over valid/ready while prog_en is high
// and sequences MAR/RAM control words to write them to consecutive addresses.
// Optional readback check of every written byte: define PROG_VERIFY_EN.
module burst_programmer
  import prog_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              prog_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [14:0]       ctrl,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              busy,
  output logic              full,
  output logic              overflow,
  input  logic [DATA_W-1:0] bus_in,
  output logic              verify_err
);

  prog_state_t       state;
  logic              prog_en_d;
  logic [DATA_W-1:0] byte_q;
  logic              cnt_load;
  logic              cnt_inc;
  logic              cnt_last;

  assign cnt_load = (state == IDLE) && prog_en && !prog_en_d;
`ifdef PROG_VERIFY_EN
  assign cnt_inc  = (state == CHECK);
`else
  assign cnt_inc  = (state == WRITE);
`endif

  prog_addr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_counter (
    .clk    (clk),
    .resetn (resetn),
    .load   (cnt_load),
    .base   (base_addr),
    .inc    (cnt_inc),
    .addr   (prog_addr),
    .full   (full),
    .last   (cnt_last)
  );

`ifdef PROG_VERIFY_EN
  logic [DATA_W-1:0] rd_q;
`else
  logic bus_in_unused;
  assign bus_in_unused = ^bus_in;
  assign verify_err    = 1'b0;
`endif

  // Session FSM with registered handshake, bus and control outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      prog_en_d  <= 1'b0;
      byte_q     <= '0;
      ctrl       <= CTRL_IDLE;
      bus_out    <= '0;
      bus_oe     <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
`ifdef PROG_VERIFY_EN
      rd_q       <= '0;
      verify_err <= 1'b0;
`endif
    end else begin
      prog_en_d <= prog_en;
      case (state)
        IDLE: begin
          ctrl       <= CTRL_IDLE;
          bus_out    <= '0;
          bus_oe     <= 1'b0;
          byte_ready <= 1'b0;
          if (cnt_load) begin
            busy       <= 1'b1;
            overflow   <= 1'b0;
            byte_ready <= 1'b1;
`ifdef PROG_VERIFY_EN
            verify_err <= 1'b0;
`endif
            state      <= WAIT;
          end
        end
        // An offered byte is honoured even if prog_en drops in the same
        // cycle, since byte_ready was already presented to the source.
        WAIT: begin
          if (byte_valid && full) overflow <= 1'b1;
          if (byte_valid && byte_ready) begin
            byte_q     <= byte_in;
            byte_ready <= 1'b0;
            bus_out    <= DATA_W'(prog_addr);
            bus_oe     <= 1'b1;
            ctrl       <= ctrl_assert(SIG_MAR_ADDR_LOAD_N);
            state      <= ADDR;
          end else if (!prog_en) begin
            busy       <= 1'b0;
            byte_ready <= 1'b0;
            state      <= IDLE;
          end else begin
            byte_ready <= !full;
          end
        end
        ADDR: begin
          bus_out <= byte_q;
          bus_oe  <= 1'b1;
          ctrl    <= ctrl_assert(SIG_MAR_MEM_LOAD_N);
          state   <= DATA;
        end
        DATA: begin
          bus_oe <= 1'b0;
          ctrl   <= ctrl_assert(SIG_RAM_LOAD_N);
          state  <= WRITE;
        end
`ifdef PROG_VERIFY_EN
        WRITE: begin
          ctrl  <= ctrl_assert(SIG_RAM_EN_N);
          state <= READ;
        end
        // RAM output stays enabled through CHECK so the bus is never floating
        READ: begin
          rd_q  <= bus_in;
          ctrl  <= ctrl_assert(SIG_RAM_EN_N);
          state <= CHECK;
        end
        CHECK: begin
          if (rd_q != byte_q) verify_err <= 1'b1;
          ctrl       <= CTRL_IDLE;
          byte_ready <= prog_en && !cnt_last;
          state      <= WAIT;
        end
`else
        WRITE: begin
          ctrl       <= CTRL_IDLE;
          byte_ready <= prog_en && !cnt_last;
          state      <= WAIT;
        end
`endif
        default: begin
          ctrl       <= CTRL_IDLE;
          bus_oe     <= 1'b0;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_programmer.sv
// Directed bench for burst_programmer with an expected-write scoreboard.
module tb_burst_programmer;

`ifdef PROG_VERIFY_EN
  localparam int CAD = 6;
  localparam bit VER = 1'b1;
`else
  localparam int CAD = 4;
  localparam bit VER = 1'b0;
`endif

  localparam logic [14:0] W_IDLE = 15'h0FE3;
  localparam logic [14:0] W_MARA = 15'h07E3;
  localparam logic [14:0] W_MARM = 15'h0BE3;
  localparam logic [14:0] W_RAML = 15'h0EE3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       prog_en = 1'b0;
  logic [3:0] base_addr = '0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [14:0] ctrl;
  logic [3:0] prog_addr;
  logic       busy;
  logic       full;
  logic       overflow;
  logic [7:0] bus_in;
  logic       verify_err;

  burst_programmer #(
    .DATA_W (8),
    .ADDR_W (4),
    .DEPTH  (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .prog_en    (prog_en),
    .base_addr  (base_addr),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .ctrl       (ctrl),
    .prog_addr  (prog_addr),
    .busy       (busy),
    .full       (full),
    .overflow   (overflow),
    .bus_in     (bus_in),
    .verify_err (verify_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         writes = 0;
  int         writes_exp = 0;
  logic [3:0] model_addr = '0;
  logic [7:0] last_byte = '0;
  bit         force_bad = 1'b0;
  logic [7:0] mon_addr = '0;
  logic [7:0] mon_data = '0;

  // RAM readback model: returns the last offered byte unless corrupted
  assign bus_in = force_bad ? 8'h00 : last_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte until accepted; returns the number of refused cycles
  task automatic send_byte(input logic [7:0] d, output int stalls);
    bit   rdy;
    bit   done;
    wr_t  e;
    stalls     = 0;
    done       = 1'b0;
    byte_in    = d;
    byte_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      rdy = byte_ready;
      step();
      if (rdy) done = 1'b1;
      else stalls++;
    end
    byte_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL accept_timeout observed=none expected=accept");
    end else begin
      last_byte = d;
      e.addr    = model_addr;
      e.data    = d;
      exp_q.push_back(e);
      writes_exp++;
      model_addr = model_addr + 4'd1;
    end
  endtask

  task automatic start_session(input logic [3:0] base);
    base_addr  = base;
    model_addr = base;
    prog_en    = 1'b1;
    step();
    chk("start_busy", busy, 1);
    chk("start_ready", byte_ready, 1);
    chk("start_addr", prog_addr, base);
  endtask

  task automatic end_session();
    prog_en = 1'b0;
    step();
    step();
    chk("end_busy", busy, 0);
  endtask

  // Write monitor: captures MAR address/data phases and scores each RAM load
  always @(negedge clk) begin
    wr_t e;
    if (resetn === 1'b1) begin
      if (ctrl[11] === 1'b0) begin
        mon_addr = bus_out;
        chk("addr_word", ctrl, W_MARA);
        chk("addr_oe", bus_oe, 1);
      end
      if (ctrl[10] === 1'b0) begin
        mon_data = bus_out;
        chk("data_word", ctrl, W_MARM);
        chk("data_oe", bus_oe, 1);
      end
      if (ctrl[8] === 1'b0) begin
        writes++;
        chk("write_word", ctrl, W_RAML);
        chk("write_oe", bus_oe, 0);
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_write observed=write expected=none");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", mon_addr, {4'h0, e.addr});
          chk("wr_data", mon_data, e.data);
        end
      end
    end
  end

  initial begin
    int st;

    // Reset values
    step();
    step();
    chk("rst_ctrl", ctrl, W_IDLE);
    chk("rst_oe", bus_oe, 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_verr", verify_err, 0);
    resetn = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Single byte with exact latency
    start_session(4'd3);
    send_byte(8'hA5, st);
    chk("single_stall", st, 0);
    chk("n1_ctrl", ctrl, W_MARA);
    chk("n1_bus", bus_out, 8'h03);
    chk("n1_ready", byte_ready, 0);
    step();
    chk("n2_ctrl", ctrl, W_MARM);
    chk("n2_bus", bus_out, 8'hA5);
    step();
    chk("n3_ctrl", ctrl, W_RAML);
    for (int k = 4; k < CAD; k++) step();
    chk("pre_ready", byte_ready, 0);
    step();
    chk("cad_ready", byte_ready, 1);
    chk("cad_ctrl", ctrl, W_IDLE);
    chk("single_addr", prog_addr, 4'd4);
    chk("single_writes", writes, 1);

    // Handshake stall: valid held while not ready
    send_byte(8'h11, st);
    send_byte(8'h22, st);
    chk("stall_cycles", st, CAD - 1);
    for (int k = 0; k < CAD; k++) step();
    chk("stall_writes", writes, 3);
    chk("stall_addr", prog_addr, 4'd6);
    end_session();

    // Wrap and full
    start_session(4'd14);
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), st);
    for (int k = 1; k < CAD; k++) step();
    chk("full_flag", full, 1);
    chk("full_addr", prog_addr, 4'd14);
    chk("full_ready", byte_ready, 0);
    chk("full_ovf0", overflow, 0);
    byte_in    = 8'hEE;
    byte_valid = 1'b1;
    step();
    step();
    byte_valid = 1'b0;
    chk("ovf_ready", byte_ready, 0);
    chk("ovf_flag", overflow, 1);
    step();
    chk("ovf_sticky", overflow, 1);
    chk("full_writes", writes, 19);
    end_session();

    // Early stop plus re-trigger while busy
    start_session(4'd5);
    chk("new_ovf_clr", overflow, 0);
    chk("new_full_clr", full, 0);
    send_byte(8'h71, st);
    send_byte(8'h72, st);
    prog_en = 1'b0;
    step();
    prog_en = 1'b1;
    step();
    chk("early_write", ctrl, W_RAML);
    prog_en = 1'b0;
    for (int k = 3; k < CAD; k++) step();
    step();
    chk("early_ready", byte_ready, 0);
    step();
    step();
    chk("early_busy", busy, 0);
    step();
    step();
    chk("early_still", busy, 0);
    chk("early_addr", prog_addr, 4'd7);
    chk("early_writes", writes, 21);

    // Reset during DATA aborts the write
    start_session(4'd9);
    send_byte(8'h99, st);
    step();
    resetn = 1'b0;
    step();
    exp_q.delete();
    writes_exp--;
    chk("mid_ctrl", ctrl, W_IDLE);
    chk("mid_oe", bus_oe, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", byte_ready, 0);
    chk("mid_addr", prog_addr, 0);
    prog_en = 1'b0;
    resetn  = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("mid_writes", writes, 21);

    // Readback mismatch, then a clean session
    start_session(4'd2);
    force_bad = 1'b1;
    send_byte(8'h5A, st);
    for (int k = 1; k < CAD; k++) step();
    chk("verr_ready", byte_ready, 1);
    chk("verr_set", verify_err, VER);
    step();
    chk("verr_sticky", verify_err, VER);
    end_session();
    force_bad = 1'b0;
    start_session(4'd8);
    chk("verr_clr", verify_err, 0);
    send_byte(8'h3C, st);
    for (int k = 1; k < CAD; k++) step();
    chk("verr_ok", verify_err, 0);
    chk("verr_addr", prog_addr, 4'd9);
    end_session();

    chk("total_writes", writes, writes_exp);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_programmer.md
Name: burst_programmer

Overview:
- Parametrised successor to the single-byte RAM programmer.
- Accepts a stream of bytes over a valid/ready handshake while programming mode is active.
- Sequences the MAR/RAM control word to write each byte to consecutive RAM addresses, starting at a loadable base address.
- Sits between the pin-level input and the shared 8-bit bus; it owns the bus and control word only while busy.

Parameters:
- DATA_W, 8, data/bus width in bits.
- ADDR_W, 4, RAM address width.
- DEPTH, 16, number of writable words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- prog_en  in  1  programming mode; a rising edge starts a session
- base_addr  in  ADDR_W  first write address, sampled on the prog_en rising edge
- byte_in  in  DATA_W  byte to program
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  block can accept a byte this cycle
- bus_out  out  DATA_W  value driven onto the shared bus
- bus_oe  out  1  bus_out drive enable
- ctrl  out  15  control word, same bit map and active levels as the CPU controller
- prog_addr  out  ADDR_W  next address to be written
- busy  out  1  session active
- full  out  1  DEPTH words written this session
- overflow  out  1  sticky: a byte was offered while full
- bus_in  in  DATA_W  bus readback (used only with PROG_VERIFY_EN)
- verify_err  out  1  sticky readback mismatch (tied 0 without PROG_VERIFY_EN)

Behaviour:
- All outputs are registered and update on posedge clk.
- Reset (resetn=0 at a posedge), effective on any cycle including mid-write:
  - state=IDLE, ctrl=CTRL_IDLE (15'b000111111100011), bus_oe=0, bus_out=0.
  - byte_ready=0, prog_addr=0, busy=0, full=0, overflow=0, verify_err=0, write count=0.
- IDLE:
  - On a prog_en 0->1 edge (prog_en_d registered): prog_addr<=base_addr, count<=0, full<=0, overflow<=0, busy<=1, go to WAIT.
- WAIT:
  - byte_ready = busy & ~full & prog_en.
  - Byte accepted when byte_valid & byte_ready: latch byte_in, go to ADDR.
  - If prog_en=0: busy<=0, go to IDLE.
- ADDR (1 cycle): bus_out={0,prog_addr}, bus_oe=1, ctrl[11] MAR_ADDR_LOAD_N=0.
- DATA (1 cycle): bus_out=latched byte, bus_oe=1, ctrl[10] MAR_MEM_LOAD_N=0.
- WRITE (1 cycle): bus_oe=0, ctrl[8] RAM_LOAD_N=0.
  - Then prog_addr<=prog_addr+1, wrapping mod 2**ADDR_W; count<=count+1.
  - full<=1 when count+1==DEPTH.
  - Go to WAIT.
- Latency and throughput:
  - Byte accepted at edge N gives the ADDR word at N+1, DATA at N+2, RAM_LOAD_N low at N+3, byte_ready high again at N+4.
  - Peak throughput is 1 byte per 4 cycles.
- Simultaneous events:
  - byte_ready is 0 outside WAIT.
  - prog_en falling mid-byte: the current write completes, then WAIT exits to IDLE.
  - A new prog_en rising edge while busy is ignored.
- Full:
  - While full, bytes are refused.
  - byte_valid while full sets overflow (sticky until the next session or reset).
- Exactly one active-level control bit deviates from CTRL_IDLE in each non-IDLE/WAIT state; all others hold CTRL_IDLE.

Optional Feature:
- Macro PROG_VERIFY_EN.
- When defined, WRITE is followed by READ then CHECK:
  - READ: ctrl[9] RAM_EN_N=0, bus_oe=0.
  - CHECK: bus_in, sampled at the end of READ, is compared with the latched byte. A mismatch sets verify_err (sticky until the next session or reset).
  - The address/count increment moves to CHECK.
  - Byte cadence becomes 6 cycles: byte_ready high again at N+6.
- When not defined: no READ/CHECK states, bus_in is unused, verify_err=0 constant.

Decomposition:
- Shared package prog_pkg holds:
  - control-bit index localparams (SIG_PC_INC=14 ... SIG_OUT_LOAD_N=0) and CTRL_IDLE;
  - the state enum (IDLE, WAIT, ADDR, DATA, WRITE, READ, CHECK).
- Both the CPU controller and this block import prog_pkg.
- One natural sub-module: prog_addr_counter (load, increment, wrap, count/full).

Test Plan:
- Reset mid-write: resetn=0 during DATA -> next edge ctrl=15'h0FE3, bus_oe=0, busy=0, byte_ready=0.
- Single byte: base_addr=3, prog_en rises, byte 8'hA5 accepted at cycle N:
  - N+1: bus_out=8'h03, ctrl[11]=0.
  - N+2: bus_out=8'hA5, ctrl[10]=0.
  - N+3: ctrl[8]=0.
  - Then prog_addr=4.
- Wrap and full: DEPTH=16, base_addr=14, 16 bytes streamed back-to-back -> addresses 14,15,0..13; full=1 after the 16th; 17th byte_valid -> byte_ready=0, overflow=1.
- Early stop: prog_en falls during ADDR of byte 2 -> byte 2 still written (RAM_LOAD_N pulse seen), then busy=0; a second rising edge while busy has no effect.
- Handshake stall: byte_valid held with byte_ready=0 for 3 cycles -> byte accepted exactly once, one write pulse.
- PROG_VERIFY_EN: bus_in forced to 8'h00 when 8'h5A is written -> verify_err=1 after CHECK, 6-cycle cadence; with a matching bus_in, verify_err stays 0.
